// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } uart_parity_e;

    // Folds the two parity parameters into a single mode value.
    function automatic uart_parity_e parityMode(input int enable, input int odd);
        if (enable == 0) begin
            return PAR_NONE;
        end
        return (odd != 0) ? PAR_ODD : PAR_EVEN;
    endfunction

    // Number of bit-centre samples taken across one complete frame.
    function automatic int frameSamples(input int dataWidth, input int parityEn, input int stopBits);
        return 1 + dataWidth + ((parityEn != 0) ? 1 : 0) + stopBits;
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick divider: one tick every CLK_DIV pclk cycles.
module uart_baud_tick_gen
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic pclk,
    input  logic areset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    // The clearing cycle already lies inside the start bit, so the new
    // period restarts one count in to keep the start sample on the half-bit.
    localparam logic [CW-1:0] RESTART = (CLK_DIV > 1) ? CW'(1) : CW'(0);

    logic [CW-1:0] count_q;

    // Free-running divider, realigned to the start edge when cleared.
    always_ff @(posedge pclk) begin
        if (areset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= RESTART;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchroniser, oversampled frame FSM and held output register.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam uart_parity_e  PAR_MODE  = parityMode(PARITY_EN, PARITY_ODD);
    localparam logic          ODD_SENSE = (PAR_MODE == PAR_ODD);

    logic rxMeta_q, rxSync_q, rxPrev_q;
    logic rxS, rxFall;
    logic tick, tickClear, sampleNow;

    uart_rx_state_e        state_q, state_d;
    logic [SW-1:0]         sampleCnt_q, sampleCnt_d;
    logic [BW-1:0]         bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parErr_q, parErr_d;
    logic                  frmErr_q, frmErr_d;
    logic                  done_q, done_d;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, parOut_q, frmOut_q, overrun_q;

    assign rxS    = rxSync_q;
    assign rxFall = rxPrev_q & ~rxS;

    // Two-flop synchroniser plus one delayed copy for start-edge detection; idle line is high.
    always_ff @(posedge pclk) begin
        if (areset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    uart_baud_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .pclk   (pclk),
        .areset (areset),
        .clear  (tickClear),
        .tick   (tick)
    );

    assign sampleNow = tick && ((state_q == START) ? (sampleCnt_q == HALF_LAST)
                                                   : (sampleCnt_q == FULL_LAST));

    // Frame FSM next-state: sample positions, deserialisation and per-frame error capture.
    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parErr_d    = parErr_q;
        frmErr_d    = frmErr_q;
        done_d      = 1'b0;
        tickClear   = 1'b0;

        if (tick && (state_q inside {START, DATA, PARITY, STOP})) begin
            sampleCnt_d = sampleNow ? '0 : sampleCnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rxFall) begin
                    state_d     = START;
                    tickClear   = 1'b1;
                    sampleCnt_d = '0;
                    bitCnt_d    = '0;
                    parErr_d    = 1'b0;
                    frmErr_d    = 1'b0;
                end
            end
            START: begin
                if (sampleNow) begin
                    state_d = rxS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sampleNow) begin
                    shift_d = {rxS, shift_q[DATA_WIDTH-1:1]};
                    if (bitCnt_q == DATA_LAST) begin
                        bitCnt_d = '0;
                        state_d  = (PAR_MODE == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sampleNow) begin
                    parErr_d = (^shift_q) ^ rxS ^ ODD_SENSE;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (sampleNow) begin
                    if (!rxS) begin
                        frmErr_d = 1'b1;
                    end
                    if (bitCnt_q == STOP_LAST) begin
                        bitCnt_d = '0;
                        done_d   = 1'b1;
                        state_d  = rxS ? IDLE : WAIT_HIGH;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame FSM state, counters, shift register and registered busy flag.
    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q     <= IDLE;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parErr_q    <= 1'b0;
            frmErr_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parErr_q    <= parErr_d;
            frmErr_q    <= frmErr_d;
            done_q      <= done_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Output holding register: loads completed frames, drops them on overrun, clears on handshake.
    always_ff @(posedge pclk) begin
        if (areset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            parOut_q  <= 1'b0;
            frmOut_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done_q) begin
                if (valid_q && !rx_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    data_q   <= shift_q;
                    parOut_q <= parErr_q;
                    frmOut_q <= frmErr_q;
                    valid_q  <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q  <= 1'b0;
                parOut_q <= 1'b0;
                frmOut_q <= 1'b0;
            end
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = parOut_q;
    assign framing_err = frmOut_q;
    assign overrun_err = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed scoreboard bench for uart_rx_ctrl: one plain 8N1 receiver and one even-parity receiver.
module tb_uart_rx_ctrl;

    localparam int BIT = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       frm;
    } exp_t;

    logic       pclk;
    logic       areset;
    logic       rxA, readyA, validA, parA, frmA, ovrA, busyA;
    logic [7:0] dataA;
    logic       rxB, readyB, validB, parB, frmB, ovrB, busyB;
    logic [7:0] dataB;

    int   cmpCnt = 0;
    int   failCnt = 0;
    int   cycleCnt = 0;
    exp_t qA[$];
    exp_t qB[$];
    exp_t expA, expB;

    int   validCyclesA = 0;
    int   riseCycleA = -1;
    int   ovrPulsesA = 0;
    int   ovrCycleA = -1;
    int   lastFallA = 0;
    int   snap = 0;
    logic prevValidA = 1'b0;

    uart_rx_ctrl #(
        .CLK_DIV(4), .OVERSAMPLE(16), .DATA_WIDTH(8),
        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dutA (
        .pclk(pclk), .areset(areset), .rx(rxA),
        .rx_data(dataA), .rx_valid(validA), .rx_ready(readyA),
        .parity_err(parA), .framing_err(frmA), .overrun_err(ovrA), .busy(busyA)
    );

    uart_rx_ctrl #(
        .CLK_DIV(4), .OVERSAMPLE(16), .DATA_WIDTH(8),
        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dutB (
        .pclk(pclk), .areset(areset), .rx(rxB),
        .rx_data(dataB), .rx_valid(validB), .rx_ready(readyB),
        .parity_err(parB), .framing_err(frmB), .overrun_err(ovrB), .busy(busyB)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmpCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tickDrive(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic setRx(input bit toB, input logic b);
        if (toB) rxB = b;
        else     rxA = b;
    endtask

    // Pushes the expected character (if any) and then drives one whole frame on the chosen line.
    task automatic applyStimulus(input bit toB, input logic [7:0] data, input bit hasPar,
                                 input bit parBit, input bit stopBit, input bit expectIt,
                                 input logic expPar, input logic expFrm);
        exp_t e;
        if (expectIt) begin
            e.data = data;
            e.par  = expPar;
            e.frm  = expFrm;
            if (toB) qB.push_back(e);
            else     qA.push_back(e);
        end
        if (!toB) lastFallA = cycleCnt;
        setRx(toB, 1'b0);
        tickDrive(BIT);
        for (int i = 0; i < 8; i++) begin
            setRx(toB, data[i]);
            tickDrive(BIT);
        end
        if (hasPar) begin
            setRx(toB, parBit);
            tickDrive(BIT);
        end
        setRx(toB, stopBit);
        tickDrive(BIT);
    endtask

    // Receiver A monitor: timing bookkeeping and scoreboard pop on every handshake.
    always @(negedge pclk) begin
        if (validA) validCyclesA++;
        if (validA && !prevValidA) riseCycleA = cycleCnt;
        prevValidA = validA;
        if (ovrA) begin
            ovrPulsesA++;
            ovrCycleA = cycleCnt;
        end
        if (validA && readyA) begin
            checkOutput("A_sb_entry", (qA.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (qA.size() > 0) begin
                expA = qA.pop_front();
                checkOutput("A_data", 32'(dataA), 32'(expA.data));
                checkOutput("A_parity_err", 32'(parA), 32'(expA.par));
                checkOutput("A_framing_err", 32'(frmA), 32'(expA.frm));
            end
        end
    end

    // Receiver B monitor: scoreboard pop on every handshake.
    always @(negedge pclk) begin
        if (validB && readyB) begin
            checkOutput("B_sb_entry", (qB.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (qB.size() > 0) begin
                expB = qB.pop_front();
                checkOutput("B_data", 32'(dataB), 32'(expB.data));
                checkOutput("B_parity_err", 32'(parB), 32'(expB.par));
                checkOutput("B_framing_err", 32'(frmB), 32'(expB.frm));
            end
        end
    end

    initial begin
        areset = 1'b1;
        rxA = 1'b1;
        rxB = 1'b1;
        readyA = 1'b0;
        readyB = 1'b0;
        tickDrive(4);
        areset = 1'b0;
        @(negedge pclk);
        checkOutput("reset_data", 32'(dataA), 32'd0);
        checkOutput("reset_valid", 32'(validA), 32'd0);
        checkOutput("reset_parity", 32'(parA), 32'd0);
        checkOutput("reset_framing", 32'(frmA), 32'd0);
        checkOutput("reset_overrun", 32'(ovrA), 32'd0);
        checkOutput("reset_busy", 32'(busyA), 32'd0);
        checkOutput("reset_B_valid", 32'(validB), 32'd0);
        checkOutput("reset_B_busy", 32'(busyB), 32'd0);
        tickDrive(1);

        $display("[TB] clean 8N1 frame 0xA5");
        readyA = 1'b1;
        validCyclesA = 0;
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tickDrive(4);
        @(negedge pclk);
        checkOutput("t1_latency", riseCycleA - lastFallA, 32'd611);
        checkOutput("t1_valid_cycles", validCyclesA, 32'd1);
        tickDrive(1);

        $display("[TB] even parity frames 0x3C");
        readyB = 1'b1;
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tickDrive(4);
        @(negedge pclk);
        checkOutput("t2_sbB_drained", qB.size(), 32'd0);
        tickDrive(1);

        $display("[TB] framing error and break");
        applyStimulus(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        snap = validCyclesA;
        tickDrive(10 * BIT);
        @(negedge pclk);
        checkOutput("t3_busy_in_break", 32'(busyA), 32'd1);
        checkOutput("t3_no_frame_in_break", validCyclesA, snap);
        tickDrive(1);
        setRx(1'b0, 1'b1);
        tickDrive(BIT);
        @(negedge pclk);
        checkOutput("t3_idle_after_high", 32'(busyA), 32'd0);
        tickDrive(1);
        applyStimulus(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tickDrive(4);
        @(negedge pclk);
        checkOutput("t3_sbA_drained", qA.size(), 32'd0);
        tickDrive(1);

        $display("[TB] short low glitch");
        snap = validCyclesA;
        setRx(1'b0, 1'b0);
        tickDrive(16);
        setRx(1'b0, 1'b1);
        tickDrive(9);
        @(negedge pclk);
        checkOutput("t4_busy_during_start", 32'(busyA), 32'd1);
        tickDrive(15);
        @(negedge pclk);
        checkOutput("t4_busy_after_sample", 32'(busyA), 32'd0);
        tickDrive(2 * BIT);
        @(negedge pclk);
        checkOutput("t4_no_valid", validCyclesA, snap);
        checkOutput("t4_no_parity_err", 32'(parA), 32'd0);
        checkOutput("t4_no_framing_err", 32'(frmA), 32'd0);
        tickDrive(1);

        $display("[TB] back-to-back frames with consumer stalled");
        readyA = 1'b0;
        ovrPulsesA = 0;
        applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tickDrive(4);
        @(negedge pclk);
        checkOutput("t5_overrun_pulses", ovrPulsesA, 32'd1);
        checkOutput("t5_overrun_timing", ovrCycleA - lastFallA, 32'd611);
        checkOutput("t5_held_data", 32'(dataA), 32'h11);
        checkOutput("t5_held_valid", 32'(validA), 32'd1);
        tickDrive(1);
        readyA = 1'b1;
        tickDrive(2);
        @(negedge pclk);
        checkOutput("t5_valid_cleared", 32'(validA), 32'd0);
        checkOutput("t5_sbA_drained", qA.size(), 32'd0);
        tickDrive(1);

        $display("[TB] reset during data bit 3");
        setRx(1'b0, 1'b0);
        tickDrive(BIT);
        setRx(1'b0, 1'b1);
        tickDrive(BIT);
        setRx(1'b0, 1'b0);
        tickDrive(BIT);
        setRx(1'b0, 1'b0);
        tickDrive(BIT);
        setRx(1'b0, 1'b1);
        tickDrive(20);
        @(negedge pclk);
        checkOutput("t6_busy_before_reset", 32'(busyA), 32'd1);
        tickDrive(1);
        areset = 1'b1;
        tickDrive(1);
        areset = 1'b0;
        @(negedge pclk);
        checkOutput("t6_reset_data", 32'(dataA), 32'd0);
        checkOutput("t6_reset_valid", 32'(validA), 32'd0);
        checkOutput("t6_reset_parity", 32'(parA), 32'd0);
        checkOutput("t6_reset_framing", 32'(frmA), 32'd0);
        checkOutput("t6_reset_overrun", 32'(ovrA), 32'd0);
        checkOutput("t6_reset_busy", 32'(busyA), 32'd0);
        tickDrive(1);
        tickDrive(2 * BIT);
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tickDrive(4);
        @(negedge pclk);
        checkOutput("t6_sbA_drained", qA.size(), 32'd0);
        checkOutput("final_sbB_drained", qB.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
        $finish;
    end

endmodule
